// File: rtl/floor_request_loader.sv
// Purpose : writer side of the floor-request slot bank; edge-captures button presses and
//           loads each new floor as a one-hot byte into a free slot, clears slots on serve.
// Latency : press sampled on edge k -> LOAD high in cycle k+2; at most one LOAD per 2 cycles.
// Backpressure: when every slot is occupied, requests wait in the latch (no loss, no LOAD).
//
// Ports:
//   clock     - rising-edge clock
//   RESET     - synchronous, active-high reset
//   BTN       - button levels, bit i = floor i (any number of bits high)
//   SERVED    - one-cycle one-hot pulse: car stopped at that floor
//   LOAD      - one-cycle write strobe to the slot bank
//   SLOT_SEL  - slot index written while LOAD=1 (0 otherwise)
//   SLOT_DATA - one-hot floor written while LOAD=1 (0 otherwise)
//   CLR       - one-cycle strobe: zero slot CLR_SEL
//   CLR_SEL   - slot index cleared while CLR=1 (0 otherwise)
//   PENDING   - floors currently held in a valid slot
//   COUNT     - number of occupied slots
//   FULL      - all slots occupied
module floor_request_loader #(
   parameter int N_FLOORS = 8,
   parameter int N_SLOTS  = 4,
   localparam int FW = $clog2(N_FLOORS),
   localparam int SW = $clog2(N_SLOTS),
   localparam int CW = $clog2(N_SLOTS + 1)
) (
   input  logic                clock,
   input  logic                RESET,
   input  logic [N_FLOORS-1:0] BTN,
   input  logic [N_FLOORS-1:0] SERVED,
   output logic                LOAD,
   output logic [SW-1:0]       SLOT_SEL,
   output logic [N_FLOORS-1:0] SLOT_DATA,
   output logic                CLR,
   output logic [SW-1:0]       CLR_SEL,
   output logic [N_FLOORS-1:0] PENDING,
   output logic [CW-1:0]       COUNT,
   output logic                FULL
);

   typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

   // Registered state
   state_t                state_q,  state_d;
   logic [N_FLOORS-1:0]   btn_q,    btn_d;
   logic [N_FLOORS-1:0]   req_q,    req_d;
   logic [N_SLOTS-1:0]    valid_q,  valid_d;
   logic [FW-1:0]         floor_q [N_SLOTS];
   logic [FW-1:0]         floor_d [N_SLOTS];
   logic [FW-1:0]         f_q,      f_d;      // floor chosen for the current write
   logic [SW-1:0]         s_q,      s_d;      // slot chosen for the current write
   logic [CW-1:0]         count_q,  count_d;
   logic                  full_q,   full_d;

   // Combinational helpers
   logic [N_FLOORS-1:0]   pending;
   logic [N_FLOORS-1:0]   new_req;
   logic [N_FLOORS-1:0]   cand;
   logic                  clr_hit;
   logic [SW-1:0]         clr_idx;
   logic                  write_kill;
   logic                  load;

   function automatic logic [FW-1:0] lowest_floor(input logic [N_FLOORS-1:0] v);
      logic [FW-1:0] r;
      r = '0;
      for (int i = N_FLOORS - 1; i >= 0; i--) begin
         if (v[i]) r = FW'(i);
      end
      return r;
   endfunction

   function automatic logic [SW-1:0] lowest_slot(input logic [N_SLOTS-1:0] v);
      logic [SW-1:0] r;
      r = '0;
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         if (v[i]) r = SW'(i);
      end
      return r;
   endfunction

   // Decode of the slot table: pending floors and the slot hit by a serve pulse.
   always_comb begin
      pending = '0;
      clr_hit = 1'b0;
      clr_idx = '0;
      for (int s = 0; s < N_SLOTS; s++) begin
         if (valid_q[s]) pending[floor_q[s]] = 1'b1;
         // SERVED is one-hot and floors are unique across slots, so at most one hit.
         if (valid_q[s] && SERVED[floor_q[s]] && !clr_hit) begin
            clr_hit = 1'b1;
            clr_idx = SW'(s);
         end
      end
   end

   always_comb begin
      // Rising edges of non-pending floors; a serve in the same cycle discards the press.
      new_req    = BTN & ~btn_q & ~pending & ~SERVED;
      write_kill = (state_q == WRITE) && SERVED[f_q];
      load       = (state_q == WRITE) && !write_kill;

      btn_d = BTN;

      req_d = (req_q | new_req) & ~SERVED;
      if (load) req_d[f_q] = 1'b0;

      valid_d = valid_q;
      floor_d = floor_q;
      if (clr_hit) valid_d[clr_idx] = 1'b0;
      if (load) begin
         valid_d[s_q] = 1'b1;
         floor_d[s_q] = f_q;
      end

      // Allocation decision uses the registered free mask, so a slot freed this
      // cycle is only seen by the next IDLE decision.
      cand    = req_q & ~SERVED;
      state_d = state_q;
      f_d     = f_q;
      s_d     = s_q;
      case (state_q)
         IDLE: begin
            if ((cand != '0) && !full_q) begin
               state_d = WRITE;
               f_d     = lowest_floor(cand);
               s_d     = lowest_slot(~valid_q);
            end
         end
         WRITE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      count_d = '0;
      for (int s = 0; s < N_SLOTS; s++) begin
         count_d = count_d + CW'(valid_d[s]);
      end
      full_d = (count_d == CW'(N_SLOTS));
   end

   always_ff @(posedge clock) begin
      if (RESET) begin
         state_q <= IDLE;
         // History takes the current levels so a button held through reset
         // needs a fresh press to request again.
         btn_q   <= BTN;
         req_q   <= '0;
         valid_q <= '0;
         for (int s = 0; s < N_SLOTS; s++) floor_q[s] <= '0;
         f_q     <= '0;
         s_q     <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         btn_q   <= btn_d;
         req_q   <= req_d;
         valid_q <= valid_d;
         floor_q <= floor_d;
         f_q     <= f_d;
         s_q     <= s_d;
         count_q <= count_d;
         full_q  <= full_d;
      end
   end

   assign LOAD      = load;
   assign SLOT_SEL  = load ? s_q : '0;
   assign SLOT_DATA = load ? (N_FLOORS'(1) << f_q) : '0;
   assign CLR       = clr_hit;
   assign CLR_SEL   = clr_idx;
   assign PENDING   = pending;
   assign COUNT     = count_q;
   assign FULL      = full_q;

endmodule

// File: tb/tb_floor_request_loader.sv
module tb_floor_request_loader;

   logic       clock = 1'b0;
   logic       RESET;
   logic [7:0] BTN;
   logic [7:0] SERVED;
   logic       LOAD;
   logic [1:0] SLOT_SEL;
   logic [7:0] SLOT_DATA;
   logic       CLR;
   logic [1:0] CLR_SEL;
   logic [7:0] PENDING;
   logic [2:0] COUNT;
   logic       FULL;

   int n_total = 0;
   int n_pass  = 0;

   floor_request_loader dut (
      .clock     (clock),
      .RESET     (RESET),
      .BTN       (BTN),
      .SERVED    (SERVED),
      .LOAD      (LOAD),
      .SLOT_SEL  (SLOT_SEL),
      .SLOT_DATA (SLOT_DATA),
      .CLR       (CLR),
      .CLR_SEL   (CLR_SEL),
      .PENDING   (PENDING),
      .COUNT     (COUNT),
      .FULL      (FULL)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".load"},  {31'd0, LOAD},     32'd0);
      chk({tag, ".sel"},   {30'd0, SLOT_SEL}, 32'd0);
      chk({tag, ".data"},  {24'd0, SLOT_DATA},32'd0);
      chk({tag, ".clr"},   {31'd0, CLR},      32'd0);
      chk({tag, ".clrsel"},{30'd0, CLR_SEL},  32'd0);
      chk({tag, ".pend"},  {24'd0, PENDING},  32'd0);
      chk({tag, ".count"}, {29'd0, COUNT},    32'd0);
      chk({tag, ".full"},  {31'd0, FULL},     32'd0);
   endtask

   task automatic chk_load(input string tag, input logic l, input logic [1:0] sel, input logic [7:0] d);
      chk({tag, ".load"}, {31'd0, LOAD},      {31'd0, l});
      chk({tag, ".sel"},  {30'd0, SLOT_SEL},  {30'd0, sel});
      chk({tag, ".data"}, {24'd0, SLOT_DATA}, {24'd0, d});
   endtask

   task automatic do_reset();
      RESET  = 1'b1;
      BTN    = 8'h00;
      SERVED = 8'h00;
      tick();
      tick();
      RESET = 1'b0;
   endtask

   // Watchdog: the directed sequence is a fixed number of cycles.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [2:0] fill_order [4];
      logic [7:0] exp_data [3];
      fill_order = '{3'd0, 3'd2, 3'd1, 3'd3};
      exp_data   = '{8'h01, 8'h02, 8'h10};

      // ---------------- reset state ----------------
      do_reset();
      chk_all_zero("reset");

      // ---------------- 1: single press latency ----------------
      BTN = 8'h04;
      tick();                                   // edge k: latch set
      chk_load("t1_k1", 1'b0, 2'd0, 8'h00);
      tick();                                   // edge k+1: WRITE
      chk_load("t1_k2", 1'b1, 2'd0, 8'h04);
      chk("t1_count_during_write", {29'd0, COUNT}, 32'd0);
      tick();
      chk_load("t1_after", 1'b0, 2'd0, 8'h00);
      chk("t1_pending", {24'd0, PENDING}, 32'h04);
      chk("t1_count",   {29'd0, COUNT},   32'd1);

      // ---------------- 2: three floors on one edge ----------------
      do_reset();
      BTN = 8'h13;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_load($sformatf("t2_w%0d", i), 1'b1, 2'(i), exp_data[i]);
         tick();
         chk($sformatf("t2_gap%0d", i), {31'd0, LOAD}, 32'd0);
      end
      chk("t2_count",   {29'd0, COUNT},   32'd3);
      chk("t2_pending", {24'd0, PENDING}, 32'h13);

      // ---------------- 3: full, serve frees slot 2, queued floor 7 loads ----------------
      do_reset();
      for (int i = 0; i < 4; i++) begin
         BTN = 8'h01 << fill_order[i];
         tick();
         tick();
         chk_load($sformatf("t3_fill%0d", i), 1'b1, 2'(i), 8'h01 << fill_order[i]);
         tick();
      end
      chk("t3_full",  {31'd0, FULL},  32'd1);
      chk("t3_count", {29'd0, COUNT}, 32'd4);
      BTN = 8'h80;
      tick();
      tick();
      chk_load("t3_blocked_a", 1'b0, 2'd0, 8'h00);
      tick();
      chk_load("t3_blocked_b", 1'b0, 2'd0, 8'h00);
      SERVED = 8'h02;
      #1;
      chk("t3_clr",    {31'd0, CLR},     32'd1);
      chk("t3_clrsel", {30'd0, CLR_SEL}, 32'd2);
      tick();
      SERVED = 8'h00;
      #1;
      chk("t3_clr_off",  {31'd0, CLR},     32'd0);
      chk("t3_not_full", {31'd0, FULL},    32'd0);
      chk("t3_count3",   {29'd0, COUNT},   32'd3);
      chk("t3_pend",     {24'd0, PENDING}, 32'h0D);
      chk("t3_noload",   {31'd0, LOAD},    32'd0);
      tick();
      chk_load("t3_reload", 1'b1, 2'd2, 8'h80);
      tick();
      chk("t3_pend_after", {24'd0, PENDING}, 32'h8D);
      chk("t3_full_again", {31'd0, FULL},    32'd1);

      // ---------------- 4: re-press of a pending floor ----------------
      do_reset();
      BTN = 8'h20;
      tick();
      tick();
      chk_load("t4_first", 1'b1, 2'd0, 8'h20);
      tick();
      BTN = 8'h00;
      tick();
      BTN = 8'h20;
      tick();
      tick();
      chk("t4_noload_a", {31'd0, LOAD}, 32'd0);
      tick();
      chk("t4_noload_b", {31'd0, LOAD},    32'd0);
      chk("t4_pending",  {24'd0, PENDING}, 32'h20);
      chk("t4_count",    {29'd0, COUNT},   32'd1);

      // ---------------- 5: serve in the exact write cycle ----------------
      BTN = 8'h28;
      tick();
      tick();                                   // WRITE for floor 3, slot 1
      SERVED = 8'h08;
      #1;
      chk_load("t5_killed", 1'b0, 2'd0, 8'h00);
      chk("t5_noclr", {31'd0, CLR}, 32'd0);
      tick();
      SERVED = 8'h00;
      #1;
      chk("t5_count",   {29'd0, COUNT},   32'd1);
      chk("t5_pending", {24'd0, PENDING}, 32'h20);
      tick();
      chk("t5_noretry", {31'd0, LOAD}, 32'd0);

      // ---------------- 6: reset during a write ----------------
      do_reset();
      BTN = 8'h03;
      tick();
      tick();
      tick();
      tick();
      tick();
      chk("t6_count2", {29'd0, COUNT}, 32'd2);
      BTN = 8'h07;
      tick();
      tick();
      chk_load("t6_write", 1'b1, 2'd2, 8'h04);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      #1;
      chk_all_zero("t6_after_reset");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t6_held%0d", i), {31'd0, LOAD}, 32'd0);
      end
      chk("t6_count0", {29'd0, COUNT}, 32'd0);
      BTN = 8'h00;
      tick();
      BTN = 8'h04;
      tick();
      tick();
      chk_load("t6_repress", 1'b1, 2'd0, 8'h04);
      tick();

      // ---------------- serve and press of the same floor together ----------------
      BTN    = 8'h44;
      SERVED = 8'h40;
      #1;
      chk("t7_noclr", {31'd0, CLR}, 32'd0);
      tick();
      SERVED = 8'h00;
      tick();
      chk("t7_noload_a", {31'd0, LOAD}, 32'd0);
      tick();
      chk("t7_noload_b", {31'd0, LOAD},    32'd0);
      chk("t7_pending",  {24'd0, PENDING}, 32'h04);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
